rtc_spi_responder: RTL



---
 rtl/rtc_pkg.sv | 35 +++
 rtl/spi_target_shift.sv | 73 +++++++
 rtl/rtc_spi_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared constants, enums and the BCD increment helper for the RTC SPI responder.
package rtc_pkg;

  localparam logic [3:0] CMD_PREFIX   = 4'hF;
  localparam logic [3:0] CMD_RESET    = 4'h0;
  localparam logic [3:0] CMD_STATUS   = 4'h2;
  localparam logic [3:0] CMD_DATETIME = 4'h4;
  localparam logic [3:0] CMD_TIME     = 4'h6;
  localparam logic [3:0] CMD_ALARM    = 4'h8;

  localparam logic [2:0] LEN_STATUS   = 3'd1;
  localparam logic [2:0] LEN_DATETIME = 3'd7;
  localparam logic [2:0] LEN_TIME     = 3'd3;
  localparam logic [2:0] LEN_ALARM    = 3'd2;

  localparam int NUM_REGS = 10;

  // Datetime and time commands stream consecutive indices starting at their base.
  typedef enum logic [3:0] {
    REG_YEAR, REG_MONTH, REG_DAY, REG_DOW, REG_HOUR, REG_MIN, REG_SEC,
    REG_STATUS, REG_ALM_H, REG_ALM_M
  } reg_idx_e;

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_READ, ST_WRITE, ST_IGNORE} state_e;

  // Returns {wrapped, next}; wraps to 00 once the value reaches max_v.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [8:0] r;
    if (v == max_v)         r = {1'b1, 8'h00};
    else if (v[3:0] == 4'h9) r = {1'b0, v[7:4] + 4'h1, 4'h0};
    else                     r = {1'b0, v[7:4], v[3:0] + 4'h1};
    return r;
  endfunction

endpackage

// File: rtl/spi_target_shift.sv
// SPI mode-0 target front end: input synchronizers, edge detect, bit counter,
// receive shifter with byte-done strobe and transmit shifter reloaded per byte.
module spi_target_shift #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_nsel,
  input  logic       i_sck,
  input  logic       i_mosi,
  input  logic [7:0] i_tx_byte,
  output logic       o_busy,
  output logic       o_byte_done,
  output logic [7:0] o_rx_byte,
  output logic       o_miso
);

  logic [SYNC_STAGES-1:0] r_nsel_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES:0]   r_sck_sync;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_rx_shift;
  logic [7:0]             r_tx_shift;
  logic                   r_load_pend;

  logic w_sel, w_sck_rise, w_sck_fall, w_mosi;

  assign w_sel      = ~r_nsel_sync[SYNC_STAGES-1];
  assign w_sck_rise =  r_sck_sync[SYNC_STAGES-1] & ~r_sck_sync[SYNC_STAGES];
  assign w_sck_fall = ~r_sck_sync[SYNC_STAGES-1] &  r_sck_sync[SYNC_STAGES];
  assign w_mosi     =  r_mosi_sync[SYNC_STAGES-1];

  // NOTE: non-blocking assignments let each synchronizer stage take the previous stage's old value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_nsel_sync <= '1;
      r_mosi_sync <= '0;
      r_sck_sync  <= '0;
    end else begin
      r_nsel_sync <= {r_nsel_sync[SYNC_STAGES-2:0], i_nsel};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-1:0], i_sck};
    end
  end

  // Deselect discards any partial byte and parks MISO high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '1;
      r_load_pend <= 1'b0;
    end else if (!w_sel) begin
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '1;
      r_load_pend <= 1'b0;
    end else if (w_sck_rise) begin
      r_rx_shift <= {r_rx_shift[5:0], w_mosi};
      r_bit_cnt  <= r_bit_cnt + 3'd1;
      if (r_bit_cnt == 3'd7) r_load_pend <= 1'b1;
    end else if (w_sck_fall) begin
      r_load_pend <= 1'b0;
      r_tx_shift  <= r_load_pend ? i_tx_byte : {r_tx_shift[6:0], 1'b1};
    end
  end

  assign o_busy      = w_sel;
  assign o_byte_done = w_sel && w_sck_rise && (r_bit_cnt == 3'd7);
  assign o_rx_byte   = {r_rx_shift, w_mosi};
  assign o_miso      = r_tx_shift[7];

endmodule

// File: rtl/rtc_spi_responder.sv
// RTC stand-in on the SPI link: command FSM, BCD register file and a 1 Hz time
// base whose ticks are deferred while a transaction is open.
module rtc_spi_responder
  import rtc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic SClk,
  input  logic Reset,
  input  logic nSel,
  input  logic SPIClk,
  input  logic SPIMosi,
  output logic SPIMiso,
  input  logic SecondTick,
  output logic DayCarry,
  output logic Busy
);

  logic       w_busy, w_byte_done;
  logic [7:0] w_rx_byte, w_tx_byte;

  state_e     r_state, w_next_state;
  logic [3:0] r_cmd;
  logic [2:0] r_idx;
  logic [7:0] r_regs [NUM_REGS];
  logic       r_pending, r_day_carry;

  reg_idx_e   w_base;
  logic [2:0] w_len;
  logic [3:0] w_addr;
  logic       w_in_range, w_cmd_done, w_cmd_valid, w_do_reset, w_commit, w_tick_now;
  logic       w_sec_wrap, w_min_wrap, w_hour_wrap;
  logic [7:0] w_sec_next, w_min_next, w_hour_next, w_dow_next;

  spi_target_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .i_clk       (SClk),
    .i_rst       (Reset),
    .i_nsel      (nSel),
    .i_sck       (SPIClk),
    .i_mosi      (SPIMosi),
    .i_tx_byte   (w_tx_byte),
    .o_busy      (w_busy),
    .o_byte_done (w_byte_done),
    .o_rx_byte   (w_rx_byte),
    .o_miso      (SPIMiso)
  );

  assign w_cmd_done  = (r_state == ST_CMD) && w_byte_done;
  assign w_cmd_valid = (w_rx_byte[7:4] == CMD_PREFIX) && (w_rx_byte[3:0] <= 4'h9) &&
                       (w_rx_byte[3:0] != 4'h1);
  assign w_do_reset  = w_cmd_done && w_cmd_valid && (w_rx_byte[3:0] == CMD_RESET);

  always_comb begin
    w_base = REG_STATUS;
    w_len  = '0;
    case (r_cmd[3:1])
      CMD_STATUS[3:1]:   begin w_base = REG_STATUS; w_len = LEN_STATUS;   end
      CMD_DATETIME[3:1]: begin w_base = REG_YEAR;   w_len = LEN_DATETIME; end
      CMD_TIME[3:1]:     begin w_base = REG_HOUR;   w_len = LEN_TIME;     end
      CMD_ALARM[3:1]:    begin w_base = REG_ALM_H;  w_len = LEN_ALARM;    end
      default: ;
    endcase
  end

  assign w_addr     = w_base + {1'b0, r_idx};
  assign w_in_range = r_idx < w_len;
  assign w_tx_byte  = (r_state == ST_READ && w_in_range) ? r_regs[w_addr] : 8'hFF;
  assign w_commit   = (r_state == ST_WRITE) && w_byte_done && w_in_range;
  assign w_tick_now = !w_busy && (SecondTick || r_pending);

  assign {w_sec_wrap, w_sec_next}   = bcd_inc(r_regs[REG_SEC], 8'h59);
  assign {w_min_wrap, w_min_next}   = bcd_inc(r_regs[REG_MIN], 8'h59);
  assign {w_hour_wrap, w_hour_next} = bcd_inc(r_regs[REG_HOUR], 8'h23);
  assign w_dow_next = (r_regs[REG_DOW] == 8'h06) ? 8'h00 : r_regs[REG_DOW] + 8'h01;

  always_ff @(posedge SClk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: the default comes first so every path assigns w_next_state and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    if (!w_busy) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next_state = ST_CMD;
        ST_CMD: if (w_byte_done) begin
          if (!w_cmd_valid || w_rx_byte[3:0] == CMD_RESET) w_next_state = ST_IGNORE;
          else if (w_rx_byte[0])                           w_next_state = ST_READ;
          else                                             w_next_state = ST_WRITE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SClk or posedge Reset) begin
    if (Reset) begin
      r_cmd     <= '0;
      r_idx     <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_cmd_done) r_cmd <= w_rx_byte[3:0];
      if (r_state == ST_CMD)                    r_idx <= '0;
      else if (w_byte_done && r_idx != 3'd7)    r_idx <= r_idx + 3'd1;
      if (!w_busy)         r_pending <= 1'b0;
      else if (SecondTick) r_pending <= 1'b1;
    end
  end

  // Commits only happen while busy and ticks only while idle, so the branches never compete.
  // NOTE: the register file is reset explicitly because its power-on contents are visible to the master.
  always_ff @(posedge SClk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
      r_regs[REG_MONTH]  <= 8'h01;
      r_regs[REG_DAY]    <= 8'h01;
      r_regs[REG_STATUS] <= 8'h80;
      r_day_carry        <= 1'b0;
    end else begin
      r_day_carry <= 1'b0;
      if (w_do_reset) begin
        r_regs[REG_YEAR]   <= 8'h00;
        r_regs[REG_MONTH]  <= 8'h01;
        r_regs[REG_DAY]    <= 8'h01;
        r_regs[REG_DOW]    <= 8'h00;
        r_regs[REG_HOUR]   <= 8'h00;
        r_regs[REG_MIN]    <= 8'h00;
        r_regs[REG_SEC]    <= 8'h00;
        r_regs[REG_STATUS] <= 8'h00;
      end else if (w_commit) begin
        r_regs[w_addr] <= (w_addr == 4'(REG_STATUS)) ? {1'b0, w_rx_byte[6:0]} : w_rx_byte;
      end else if (w_tick_now) begin
        r_regs[REG_SEC] <= w_sec_next;
        if (w_sec_wrap) begin
          r_regs[REG_MIN] <= w_min_next;
          if (w_min_wrap) begin
            r_regs[REG_HOUR] <= w_hour_next;
            if (w_hour_wrap) begin
              r_regs[REG_DOW] <= w_dow_next;
              r_day_carry     <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign DayCarry = r_day_carry;
  assign Busy     = w_busy;

endmodule
